// File: rtl/thermo_pkg.sv
// thermo_pkg: shared mode encoding and default thresholds for the thermostat controller
package thermo_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, COOL = 2'b01, HEAT = 2'b10} mode_t;
  localparam int DEF_HEAT_ON  = 12;
  localparam int DEF_COOL_ON  = 18;
  localparam int DEF_HEAT_OFF = 20;
  localparam int DEF_COOL_OFF = 14;
  localparam int DEF_EMERG_HI = 26;
  localparam int DEF_EMERG_LO = 8;
endpackage

// File: rtl/thermo_chan.sv
// thermo_chan: one thermostat channel (mode register, dwell counter, hysteresis/emergency next-state)
//   clk/rst: clock, sync active-high reset; en: channel enable; valid: sample strobe; inp: W-bit sample
//   out: registered mode; changed: pulse when mode changes; hold: dwell counter nonzero
module thermo_chan
  import thermo_pkg::*;
#(
  parameter int W = 5,
  parameter int DWELL = 4,
  parameter logic [W-1:0] HEAT_ON  = W'(DEF_HEAT_ON),
  parameter logic [W-1:0] COOL_ON  = W'(DEF_COOL_ON),
  parameter logic [W-1:0] HEAT_OFF = W'(DEF_HEAT_OFF),
  parameter logic [W-1:0] COOL_OFF = W'(DEF_COOL_OFF),
  parameter logic [W-1:0] EMERG_HI = W'(DEF_EMERG_HI),
  parameter logic [W-1:0] EMERG_LO = W'(DEF_EMERG_LO)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         valid,
  input  logic [W-1:0] inp,
  output logic [1:0]   out,
  output logic         changed,
  output logic         hold
);
  localparam int DW = $clog2(DWELL + 1);
  mode_t mode, hys, tgt;
  logic emg;
  logic [DW-1:0] dwell;
  always_comb begin
    emg = (mode == HEAT && inp > EMERG_HI) || (mode == COOL && inp < EMERG_LO);
    hys = mode == IDLE ? (inp < HEAT_ON ? HEAT : inp > COOL_ON ? COOL : IDLE)
        : mode == HEAT ? (inp > HEAT_OFF ? IDLE : HEAT)
        : (inp < COOL_OFF ? IDLE : COOL);
    // emergency always flips to the opposite active mode, ahead of hysteresis
    tgt = emg ? (mode == HEAT ? COOL : HEAT) : hys;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mode    <= IDLE;
      dwell   <= '0;
      changed <= 1'b0;
    end else if (!en) begin
      mode    <= IDLE;
      dwell   <= '0;
      changed <= mode != IDLE;
    end else if (valid && (emg || (dwell == '0 && hys != mode))) begin
      mode    <= tgt;
      dwell   <= DW'(DWELL);
      changed <= 1'b1;
    end else begin
      dwell   <= dwell == '0 ? dwell : dwell - DW'(1);
      changed <= 1'b0;
    end
  end
  assign out  = mode;
  assign hold = |dwell;
endmodule

// File: rtl/thermo_ctrl.sv
// thermo_ctrl: N independent hysteresis thermostat channels with dwell and emergency override
//   en/inp_valid: per-channel enable and sample strobe; inp: channel c sample at [c*W +: W]
//   out: channel c mode at [2c +: 2]; changed: per-channel change pulse; hold: per-channel dwell active
module thermo_ctrl
  import thermo_pkg::*;
#(
  parameter int W = 5,
  parameter int N = 2,
  parameter int DWELL = 4,
  parameter logic [W-1:0] HEAT_ON  = W'(DEF_HEAT_ON),
  parameter logic [W-1:0] COOL_ON  = W'(DEF_COOL_ON),
  parameter logic [W-1:0] HEAT_OFF = W'(DEF_HEAT_OFF),
  parameter logic [W-1:0] COOL_OFF = W'(DEF_COOL_OFF),
  parameter logic [W-1:0] EMERG_HI = W'(DEF_EMERG_HI),
  parameter logic [W-1:0] EMERG_LO = W'(DEF_EMERG_LO)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   en,
  input  logic [N*W-1:0] inp,
  input  logic [N-1:0]   inp_valid,
  output logic [2*N-1:0] out,
  output logic [N-1:0]   changed,
  output logic [N-1:0]   hold
);
  for (genvar c = 0; c < N; c++) begin : g_ch
    thermo_chan #(
      .W(W), .DWELL(DWELL),
      .HEAT_ON(HEAT_ON), .COOL_ON(COOL_ON), .HEAT_OFF(HEAT_OFF),
      .COOL_OFF(COOL_OFF), .EMERG_HI(EMERG_HI), .EMERG_LO(EMERG_LO)
    ) u_chan (
      .clk(clk),
      .rst(rst),
      .en(en[c]),
      .valid(inp_valid[c]),
      .inp(inp[c*W +: W]),
      .out(out[2*c +: 2]),
      .changed(changed[c]),
      .hold(hold[c])
    );
  end
endmodule

// File: tb/tb_thermo_ctrl.sv
// tb_thermo_ctrl: directed literal checks plus randomized run against a behavioural channel model
module tb_thermo_ctrl;
  localparam int W = 5, N = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] en = '0, inp_valid = '0, changed, hold;
  logic [N*W-1:0] inp = '0;
  logic [2*N-1:0] out;
  int errs = 0, checks = 0;
  int m_mode[N], m_dwell[N], m_chg[N];
  bit started = 0;

  thermo_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .inp(inp), .inp_valid(inp_valid),
    .out(out), .changed(changed), .hold(hold)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Modes as spec numbers: 0 idle, 1 cool, 2 heat; thresholds are the spec defaults.
  always @(posedge clk) begin
    if (rst) started = 1;
    for (int c = 0; c < N; c++) begin
      int x, nm;
      bit emerg;
      x = int'(inp[c*W +: W]);
      nm = m_mode[c];
      emerg = 0;
      if (rst) begin
        m_mode[c] = 0; m_dwell[c] = 0; m_chg[c] = 0;
      end else if (!en[c]) begin
        m_chg[c] = (m_mode[c] != 0);
        m_mode[c] = 0; m_dwell[c] = 0;
      end else begin
        if (inp_valid[c]) begin
          if (m_mode[c] == 0) nm = x < 12 ? 2 : (x > 18 ? 1 : 0);
          else if (m_mode[c] == 2) begin
            if (x > 26) begin nm = 1; emerg = 1; end
            else if (x > 20) nm = 0;
          end else begin
            if (x < 8) begin nm = 2; emerg = 1; end
            else if (x < 14) nm = 0;
          end
        end
        if (emerg || (nm != m_mode[c] && m_dwell[c] == 0)) begin
          m_chg[c] = 1; m_mode[c] = nm; m_dwell[c] = 4;
        end else begin
          m_chg[c] = 0;
          if (m_dwell[c] > 0) m_dwell[c]--;
        end
      end
    end
  end

  always @(negedge clk) if (started)
    for (int c = 0; c < N; c++) begin
      chk($sformatf("model out[%0d]", c), int'(out[2*c +: 2]), m_mode[c]);
      chk($sformatf("model changed[%0d]", c), int'(changed[c]), m_chg[c]);
      chk($sformatf("model hold[%0d]", c), int'(hold[c]), int'(m_dwell[c] > 0));
    end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] e, input logic [1:0] v, input int x0, input int x1);
    en = e; inp_valid = v;
    inp = {W'(x1), W'(x0)};
  endtask

  initial begin
    drive(2'b11, 2'b11, 11, 11);
    rst = 1; cyc(); cyc();
    chk("reset out", int'(out), 0);
    chk("reset changed", int'(changed), 0);
    chk("reset hold", int'(hold), 0);
    rst = 0;
    drive(2'b11, 2'b01, 11, 0); cyc();
    chk("heat on out0", int'(out[1:0]), 2);
    chk("heat on changed0", int'(changed[0]), 1);
    chk("heat on hold0", int'(hold[0]), 1);
    drive(2'b11, 2'b01, 21, 0); cyc();
    chk("dwell block out0", int'(out[1:0]), 2);
    chk("dwell block changed0", int'(changed[0]), 0);
    drive(2'b11, 2'b00, 0, 0);
    cyc(); chk("hold cyc3", int'(hold[0]), 1);
    cyc(); chk("hold cyc4", int'(hold[0]), 1);
    cyc(); chk("hold fall", int'(hold[0]), 0);
    drive(2'b11, 2'b01, 21, 0); cyc();
    chk("heat off out0", int'(out[1:0]), 0);
    chk("heat off changed0", int'(changed[0]), 1);
    drive(2'b11, 2'b00, 0, 0);
    repeat (4) cyc();
    drive(2'b11, 2'b01, 11, 0); cyc();
    chk("reheat out0", int'(out[1:0]), 2);
    drive(2'b11, 2'b01, 26, 0); cyc();
    chk("no emerg at 26", int'(out[1:0]), 2);
    chk("no emerg changed", int'(changed[0]), 0);
    drive(2'b11, 2'b01, 27, 0); cyc();
    chk("emerg out0", int'(out[1:0]), 1);
    chk("emerg changed0", int'(changed[0]), 1);
    chk("emerg hold0", int'(hold[0]), 1);
    drive(2'b11, 2'b10, 0, 12); cyc();
    chk("eq 12 out1", int'(out[3:2]), 0);
    chk("eq 12 changed1", int'(changed[1]), 0);
    drive(2'b11, 2'b10, 0, 18); cyc();
    chk("eq 18 out1", int'(out[3:2]), 0);
    chk("eq 18 changed1", int'(changed[1]), 0);
    drive(2'b11, 2'b10, 0, 19); cyc();
    chk("cool on out1", int'(out[3:2]), 1);
    drive(2'b01, 2'b00, 0, 0); cyc();
    chk("en drop out1", int'(out[3:2]), 0);
    chk("en drop changed1", int'(changed[1]), 1);
    chk("en drop hold1", int'(hold[1]), 0);
    chk("en drop ch0 out", int'(out[1:0]), 1);
    chk("en drop ch0 changed", int'(changed[0]), 0);
    drive(2'b11, 2'b10, 0, 11); cyc();
    chk("mid dwell hold1", int'(hold[1]), 1);
    drive(2'b11, 2'b00, 0, 0); rst = 1; cyc();
    chk("rst mid out", int'(out), 0);
    chk("rst mid hold", int'(hold), 0);
    chk("rst mid changed", int'(changed), 0);
    rst = 0;
    drive(2'b11, 2'b01, 19, 0); cyc();
    chk("post rst cool out0", int'(out[1:0]), 1);
    chk("post rst changed0", int'(changed[0]), 1);
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] e, v;
      e = {1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 15) != 0)};
      v = 2'($urandom);
      drive(e, v, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      rst = ($urandom_range(0, 199) == 0);
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/thermo_ctrl.md
THERMO_CTRL -- requirements
Module: thermo_ctrl

Interface
REQ-001 SHALL have parameter W, default 5: temperature sample width in bits (unsigned).
REQ-002 SHALL have parameter N, default 2: number of independent channels.
REQ-003 SHALL have parameter DWELL, default 4: minimum cycles a channel holds a mode after a non-emergency change (range 1..255).
REQ-004 SHALL have parameters HEAT_ON=12, COOL_ON=18, HEAT_OFF=20, COOL_OFF=14, EMERG_HI=26, EMERG_LO=8, each W bits wide.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port en, input, N bits: per-channel enable.
REQ-008 SHALL have port inp, input, N*W bits: channel c sample at bits [c*W +: W].
REQ-009 SHALL have port inp_valid, input, N bits: channel c sample is valid this cycle.
REQ-010 SHALL have port out, output, 2*N bits: channel c mode at [2c +: 2]. Encoding: IDLE=00, COOL=01, HEAT=10; 11 is never driven.
REQ-011 SHALL have port changed, output, N bits: one-cycle pulse in the cycle out[c] takes a new value.
REQ-012 SHALL have port hold, output, N bits: high while channel c dwell counter is nonzero.

Function
REQ-013 SHALL evaluate each channel only in cycles where inp_valid[c]=1 and en[c]=1; otherwise the mode holds.
REQ-014 SHALL register all outputs; out[c] reflects a valid sample exactly one cycle after it is presented.
REQ-015 SHALL apply these IDLE transitions: inp<HEAT_ON -> HEAT; else inp>COOL_ON -> COOL; else stay.
REQ-016 SHALL apply these HEAT transitions: inp>EMERG_HI -> COOL (emergency); else inp>HEAT_OFF -> IDLE; else stay.
REQ-017 SHALL apply these COOL transitions: inp<EMERG_LO -> HEAT (emergency); else inp<COOL_OFF -> IDLE; else stay.
REQ-018 SHALL evaluate the emergency comparison before the hysteresis comparison in every state.
REQ-019 SHALL use strict unsigned comparisons at full width W; a sample equal to a threshold does not trigger that transition.
REQ-020 SHALL load the dwell counter with DWELL on every non-emergency mode change; it decrements by 1 per cycle to 0 and saturates there.
REQ-021 SHALL ignore non-emergency transitions while dwell>0; emergency transitions SHALL bypass the dwell and reload it with DWELL.
REQ-022 SHALL force the channel to IDLE on the cycle after en[c] falls, clear its dwell counter, and pulse changed[c] if the prior mode was not IDLE.
REQ-023 SHALL pulse changed[c] only when the mode value actually differs; a stay produces no pulse.
REQ-024 SHALL keep channels fully independent; simultaneous valid samples on all channels are processed in the same cycle.

Reset
REQ-025 SHALL, while rst=1 at a clk edge, set out to all-IDLE, changed=0, hold=0 and all dwell counters to 0, overriding en and inp_valid.
REQ-026 SHALL accept a valid sample in the first cycle after rst deasserts, with no dwell blocking.
REQ-027 SHALL apply reset mid-dwell immediately: the counter clears and no changed pulse is generated.

Structure
REQ-028 SHALL place the mode encoding constants (IDLE/COOL/HEAT) and default threshold values in a shared package thermo_pkg.
REQ-029 SHALL implement one channel (mode register, dwell counter, next-state logic) as sub-module thermo_chan, instantiated N times by generate loop.
REQ-030 SHALL size the dwell counter at clog2(DWELL+1) bits.

Verification
REQ-031 SHALL cover, on ch0 in IDLE, valid inp=11 -> next cycle out=HEAT, changed=1, hold=1 for 4 cycles.
REQ-032 SHALL cover dwell blocking: HEAT with dwell active, inp=21 -> mode stays HEAT; the same inp=21 after hold falls -> IDLE.
REQ-033 SHALL cover an emergency transition: HEAT with dwell active, inp=27 -> COOL next cycle; inp=26 -> no emergency.
REQ-034 SHALL cover threshold equality: IDLE with inp=12 and inp=18 -> stays IDLE, changed=0.
REQ-035 SHALL cover enable drop: ch1 in COOL, en[1]=0 -> out[3:2]=IDLE next cycle, changed[1]=1; ch0 unaffected.
REQ-036 SHALL cover reset mid-dwell: rst=1 for one cycle -> out=0, hold=0; next valid inp=19 -> COOL.
